icache_sramlike: RTL and testbench

- Direct-mapped, read-only instruction cache between the instruction-fetch stage's sram-like master port and the AXI4 read channel.
- Hits return in 1 cycle after address acceptance; back-to-back hits are pipelined.
- Misses refill a full line with one INCR burst.
- Uncached requests bypass the arrays with a single-beat read.

---
 rtl/icache_sramlike_if.sv | 48 ++++
 rtl/icache_sramlike.sv | 141 ++++++++++++++
 tb/tb_icache_sramlike.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/icache_sramlike_if.sv
// Bus bundles for the instruction cache: the fetch-side sram-like port and the AXI4 read channel.
// sram-like: a request is taken when inst_req & inst_addr_ok; each taken request gets exactly one inst_data_ok later, in order.
// AXI: a beat or address transfers when valid & ready; the sender holds the payload stable until then.
interface icache_sram_if;
   logic        inst_req;
   logic        inst_wr;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr;
   logic [31:0] inst_wdata;
   logic        inst_uncached;
   logic        inst_addr_ok;
   logic        inst_data_ok;
   logic [31:0] inst_rdata;

   modport master (
      output inst_req, inst_wr, inst_size, inst_addr, inst_wdata, inst_uncached,
      input  inst_addr_ok, inst_data_ok, inst_rdata
   );
   modport slave (
      input  inst_req, inst_wr, inst_size, inst_addr, inst_wdata, inst_uncached,
      output inst_addr_ok, inst_data_ok, inst_rdata
   );
endinterface

interface icache_axi_r_if;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst;
   logic        arvalid;
   logic        arready;
   logic [3:0]  rid;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rlast;
   logic        rvalid;
   logic        rready;

   modport master (
      output arid, araddr, arlen, arsize, arburst, arvalid, rready,
      input  arready, rid, rdata, rresp, rlast, rvalid
   );
   modport slave (
      input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
      output arready, rid, rdata, rresp, rlast, rvalid
   );
endinterface

// File: rtl/icache_sramlike.sv
// Direct-mapped read-only instruction cache: 1-cycle pipelined hits, full-line INCR refill on miss,
// single-beat bypass for uncached fetches. One transaction outstanding at a time.
module icache_sramlike #(
   parameter int         LINE_WORDS = 8,
   parameter int         SETS       = 64,
   parameter logic [3:0] AXI_ID     = 4'd0
) (
   input  logic           clk,
   input  logic           rst,
   input  logic           invalidate,
   icache_sram_if.slave   inst,
   icache_axi_r_if.master axi,
   output logic [2:0]     dbg_state
);
   localparam int WB = $clog2(LINE_WORDS);
   localparam int SB = $clog2(SETS);
   localparam int TW = 30 - WB - SB;

   localparam logic [2:0] IDLE    = 3'd0;
   localparam logic [2:0] LOOKUP  = 3'd1;
   localparam logic [2:0] MISS_AR = 3'd2;
   localparam logic [2:0] MISS_R  = 3'd3;
   localparam logic [2:0] UC_AR   = 3'd4;
   localparam logic [2:0] UC_R    = 3'd5;
   localparam logic [2:0] DONE    = 3'd6;

   logic [2:0]    state, state_nx, after_resp;
   logic [31:0]   req_addr;
   logic          inv_pending;
   logic [31:0]   ret_word;
   logic [WB-1:0] beat_cnt;
   logic [SETS-1:0] valid;
   logic [TW-1:0] tag_mem [SETS];
   logic [31:0]   data_mem [SETS*LINE_WORDS];

   logic [WB-1:0] req_word;
   logic [SB-1:0] req_set;
   logic [TW-1:0] req_tag;
   logic          hit, addr_ok, accept, refill_last;

   assign req_word = req_addr[WB+1:2];
   assign req_set  = req_addr[WB+SB+1:WB+2];
   assign req_tag  = req_addr[31:WB+SB+2];

   assign hit         = (state == LOOKUP) && valid[req_set] && (tag_mem[req_set] == req_tag);
   assign refill_last = (state == MISS_R) && axi.rvalid && axi.rlast;

   // Accepts are gated by the registered inv_pending only, except in IDLE where a fresh
   // invalidate pulse is serviced immediately and blocks the accept that cycle.
   always_comb begin
      addr_ok = 1'b0;
      case (state)
         IDLE:    addr_ok = ~inv_pending & ~invalidate;
         LOOKUP:  addr_ok = hit & ~inv_pending;
         DONE:    addr_ok = ~inv_pending;
         default: addr_ok = 1'b0;
      endcase
      addr_ok = addr_ok & ~rst;
   end

   assign accept     = inst.inst_req & addr_ok;
   assign after_resp = accept ? (inst.inst_uncached ? UC_AR : LOOKUP) : IDLE;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = after_resp;
         LOOKUP:  state_nx = hit ? after_resp : MISS_AR;
         DONE:    state_nx = after_resp;
         MISS_AR: if (axi.arready) state_nx = MISS_R;
         MISS_R:  if (axi.rvalid && axi.rlast) state_nx = DONE;
         UC_AR:   if (axi.arready) state_nx = UC_R;
         UC_R:    if (axi.rvalid) state_nx = DONE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         valid       <= '0;
         inv_pending <= 1'b0;
         req_addr    <= 32'd0;
         ret_word    <= 32'd0;
         beat_cnt    <= '0;
      end else begin
         state <= state_nx;
         if (accept) req_addr <= inst.inst_addr;

         if (state == IDLE && (inv_pending || invalidate)) inv_pending <= 1'b0;
         else if (invalidate)                               inv_pending <= 1'b1;

         // A refill that overlaps an invalidate must not leave its line valid.
         if (state == IDLE && (inv_pending || invalidate)) valid <= '0;
         else if (refill_last && !invalidate && !inv_pending) valid[req_set] <= 1'b1;

         if (state == MISS_AR) beat_cnt <= '0;
         else if (state == MISS_R && axi.rvalid) beat_cnt <= beat_cnt + 1'b1;

         if ((state == MISS_R && axi.rvalid && beat_cnt == req_word) ||
             (state == UC_R && axi.rvalid))
            ret_word <= axi.rdata;
      end
   end

   always_ff @(posedge clk) begin
      if (state == MISS_R && axi.rvalid) data_mem[{req_set, beat_cnt}] <= axi.rdata;
      if (refill_last) tag_mem[req_set] <= req_tag;
   end

   always_comb begin
      inst.inst_rdata = 32'd0;
      if (hit)                inst.inst_rdata = data_mem[{req_set, req_word}];
      else if (state == DONE) inst.inst_rdata = ret_word;
   end

   assign inst.inst_addr_ok = addr_ok;
   assign inst.inst_data_ok = hit || (state == DONE);

   always_comb begin
      axi.araddr = 32'd0;
      axi.arlen  = 8'd0;
      if (state == MISS_AR) begin
         axi.araddr = {req_addr[31:WB+2], {(WB+2){1'b0}}};
         axi.arlen  = 8'(LINE_WORDS - 1);
      end else if (state == UC_AR) begin
         axi.araddr = {req_addr[31:2], 2'b00};
      end
   end

   assign axi.arvalid = (state == MISS_AR) || (state == UC_AR);
   assign axi.arburst = axi.arvalid ? 2'b01 : 2'b00;
   assign axi.arsize  = 3'b010;
   assign axi.arid    = AXI_ID;
   assign axi.rready  = (state == MISS_R) || (state == UC_R);
   assign dbg_state   = state;

   logic unused_bits;
   assign unused_bits = ^{inst.inst_wr, inst.inst_size, inst.inst_wdata,
                          axi.rid, axi.rresp, req_addr[1:0]};
endmodule

// File: tb/tb_icache_sramlike.sv
// Bench for icache_sramlike: vector table plus hand sequences against an AXI memory model,
// responses checked through an expected-data queue.
module tb_icache_sramlike;
   logic clk, rst, invalidate;
   logic [2:0] dbg_state;
   icache_sram_if  sram();
   icache_axi_r_if axi();

   icache_sramlike #(.LINE_WORDS(8), .SETS(64), .AXI_ID(4'd0)) dut (
      .clk(clk), .rst(rst), .invalidate(invalidate),
      .inst(sram.slave), .axi(axi.master), .dbg_state(dbg_state)
   );

   typedef struct {
      logic [31:0] addr;
      logic        uc;
      int          ar_dly;
      int          r_dly;
      bit          rnd;
      int          new_ar;
      logic [31:0] exp_araddr;
      logic [7:0]  exp_arlen;
   } vec_t;

   int vectors = 0, miscompares = 0, cyc = 0;
   logic [31:0] exp_q[$];

   int ar_dly = 0, r_dly = 0;
   bit rand_gaps = 0;
   logic [1:0] resp_mode = 2'b00;
   int ar_count = 0, beats_acc = 0, rlast_cyc = 0, dok_cyc = 0, dok_n = 0;
   logic [31:0] last_araddr;
   logic [7:0]  last_arlen;
   logic [1:0]  last_arburst;
   logic [2:0]  last_arsize;

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   function automatic logic [31:0] mem_model(logic [31:0] a);
      return {a[15:2], a[31:16], 2'b01} ^ 32'h3C5A_9E17;
   endfunction

   function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endfunction

   function automatic int next_gap();
      return rand_gaps ? int'($urandom_range(0, 2)) : r_dly;
   endfunction

   // AXI read slave model
   int s_state = 0, s_wait = 0, s_beat = 0, s_n = 0, s_gap = 0;
   logic [31:0] s_addr;
   initial begin
      axi.arready = 1'b0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
      axi.rdata = 32'd0; axi.rresp = 2'b00; axi.rid = 4'd0;
      forever begin
         @(negedge clk);
         axi.arready = 1'b0;
         if (rst) begin
            s_state = 0; s_wait = 0; axi.rvalid = 1'b0; axi.rlast = 1'b0;
         end else if (s_state == 0) begin
            if (axi.arvalid) begin
               if (s_wait >= ar_dly) begin
                  axi.arready = 1'b1;
                  ar_count++;
                  last_araddr = axi.araddr; last_arlen = axi.arlen;
                  last_arburst = axi.arburst; last_arsize = axi.arsize;
                  s_addr = axi.araddr; s_n = int'(axi.arlen) + 1;
                  s_beat = 0; s_wait = 0; s_gap = next_gap(); s_state = 1;
               end else s_wait++;
            end
         end else begin
            if (axi.rvalid) begin
               beats_acc++;
               if (axi.rlast) rlast_cyc = cyc;
               s_beat++; axi.rvalid = 1'b0; axi.rlast = 1'b0; s_gap = next_gap();
            end
            if (s_beat == s_n) s_state = 0;
            else if (s_gap > 0) s_gap--;
            else begin
               axi.rvalid = 1'b1;
               axi.rdata  = mem_model(s_addr + 32'(4 * s_beat));
               axi.rlast  = (s_beat == s_n - 1);
               axi.rresp  = resp_mode;
               axi.rid    = 4'($urandom_range(0, 15));
               chk("rready_on_beat", 32'(axi.rready), 32'd1);
            end
         end
      end
   end

   // scoreboard: pop one expected word per data_ok
   initial begin
      logic [31:0] e;
      forever begin
         @(negedge clk);
         if (!rst && sram.inst_data_ok) begin
            dok_cyc = cyc; dok_n++;
            if (exp_q.size() == 0) begin
               vectors++; miscompares++;
               $display("FAIL unexpected_data_ok: got rdata %h expected no response", sram.inst_rdata);
            end else begin
               e = exp_q.pop_front();
               chk("rdata", sram.inst_rdata, e);
            end
         end
      end
   end

   // driver tasks
   task automatic send(input logic [31:0] a, input logic uc, output int waited);
      waited = 0;
      sram.inst_req = 1'b1; sram.inst_addr = a; sram.inst_uncached = uc;
      sram.inst_wdata = $urandom;
      while (sram.inst_addr_ok !== 1'b1 && waited < 300) begin
         @(negedge clk); waited++;
      end
      chk("accept", 32'(sram.inst_addr_ok), 32'd1);
      if (sram.inst_addr_ok === 1'b1) exp_q.push_back(mem_model(a));
      @(negedge clk);
      sram.inst_req = 1'b0; sram.inst_uncached = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 500) begin
         @(negedge clk); n++;
      end
      chk("drain_pending", 32'(exp_q.size()), 32'd0);
      exp_q.delete();
      @(negedge clk);
   endtask

   task automatic check_reset(input string tag);
      chk({tag, "_addr_ok"},  32'(sram.inst_addr_ok), 32'd0);
      chk({tag, "_data_ok"},  32'(sram.inst_data_ok), 32'd0);
      chk({tag, "_rdata"},    sram.inst_rdata, 32'd0);
      chk({tag, "_arvalid"},  32'(axi.arvalid), 32'd0);
      chk({tag, "_rready"},   32'(axi.rready), 32'd0);
      chk({tag, "_araddr"},   axi.araddr, 32'd0);
      chk({tag, "_arlen"},    32'(axi.arlen), 32'd0);
      chk({tag, "_arburst"},  32'(axi.arburst), 32'd0);
      chk({tag, "_arid"},     32'(axi.arid), 32'd0);
      chk({tag, "_arsize"},   32'(axi.arsize), 32'd2);
      chk({tag, "_state"},    32'(dbg_state), 32'd0);
   endtask

   initial begin
      #200000;
      miscompares++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      vec_t vecs[8];
      int w0, w1, ar0, b0, d0, n;
      vecs[0] = '{32'h1FC0_0014, 1'b0, 0, 0, 1'b0, 1, 32'h1FC0_0000, 8'd7};
      vecs[1] = '{32'hBFC0_0008, 1'b1, 3, 2, 1'b0, 1, 32'hBFC0_0008, 8'd0};
      vecs[2] = '{32'hBFC0_0008, 1'b1, 0, 0, 1'b0, 1, 32'hBFC0_0008, 8'd0};
      vecs[3] = '{32'h0000_0000, 1'b0, 0, 0, 1'b0, 1, 32'h0000_0000, 8'd7};
      vecs[4] = '{32'h0000_0800, 1'b0, 0, 1, 1'b0, 1, 32'h0000_0800, 8'd7};
      vecs[5] = '{32'h0000_0004, 1'b0, 0, 0, 1'b0, 1, 32'h0000_0000, 8'd7};
      vecs[6] = '{32'h0000_0824, 1'b0, 1, 0, 1'b1, 1, 32'h0000_0820, 8'd7};
      vecs[7] = '{32'h0000_0838, 1'b0, 0, 0, 1'b0, 0, 32'h0000_0000, 8'd0};

      rst = 1'b1; invalidate = 1'b0;
      sram.inst_req = 1'b0; sram.inst_wr = 1'b0; sram.inst_size = 2'b10;
      sram.inst_addr = 32'd0; sram.inst_wdata = 32'd0; sram.inst_uncached = 1'b0;
      repeat (3) @(negedge clk);
      check_reset("reset");
      rst = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         ar_dly = vecs[i].ar_dly; r_dly = vecs[i].r_dly; rand_gaps = vecs[i].rnd;
         ar0 = ar_count;
         send(vecs[i].addr, vecs[i].uc, w0);
         drain();
         chk($sformatf("v%0d_ar_count", i), 32'(ar_count - ar0), 32'(vecs[i].new_ar));
         if (vecs[i].new_ar != 0) begin
            chk($sformatf("v%0d_araddr", i), last_araddr, vecs[i].exp_araddr);
            chk($sformatf("v%0d_arlen", i), 32'(last_arlen), 32'(vecs[i].exp_arlen));
            chk($sformatf("v%0d_arburst", i), 32'(last_arburst), 32'd1);
            chk($sformatf("v%0d_arsize", i), 32'(last_arsize), 32'd2);
            chk($sformatf("v%0d_dok_after_rlast", i), 32'(dok_cyc), 32'(rlast_cyc));
         end
      end
      ar_dly = 0; r_dly = 0; rand_gaps = 0;

      // refill then two back-to-back hits
      send(32'h1FC0_0014, 1'b0, w0);
      drain();
      ar0 = ar_count; d0 = dok_n;
      send(32'h1FC0_0000, 1'b0, w0);
      chk("b2b_hit1_data_ok", 32'(sram.inst_data_ok), 32'd1);
      chk("b2b_hit1_addr_ok", 32'(sram.inst_addr_ok), 32'd1);
      send(32'h1FC0_001C, 1'b0, w1);
      chk("b2b_second_wait", 32'(w1), 32'd0);
      chk("b2b_hit2_data_ok", 32'(sram.inst_data_ok), 32'd1);
      chk("b2b_hit2_addr_ok", 32'(sram.inst_addr_ok), 32'd1);
      drain();
      chk("b2b_no_ar", 32'(ar_count - ar0), 32'd0);
      chk("b2b_responses", 32'(dok_n - d0), 32'd2);

      // invalidate while idle
      invalidate = 1'b1; #1;
      chk("inv_blocks_accept", 32'(sram.inst_addr_ok), 32'd0);
      @(negedge clk);
      invalidate = 1'b0; #1;
      chk("inv_accept_resumes", 32'(sram.inst_addr_ok), 32'd1);
      ar0 = ar_count;
      send(32'h1FC0_0000, 1'b0, w0);
      drain();
      chk("inv_refetch_ar", 32'(ar_count - ar0), 32'd1);

      // invalidate during the refill burst
      r_dly = 1; ar0 = ar_count; b0 = beats_acc;
      send(32'h0000_0040, 1'b0, w0);
      n = 0;
      while (beats_acc == b0 && n < 200) begin @(negedge clk); n++; end
      chk("inv_missr_reached", 32'(beats_acc != b0), 32'd1);
      invalidate = 1'b1;
      @(negedge clk);
      invalidate = 1'b0;
      drain();
      send(32'h0000_0040, 1'b0, w0);
      drain();
      chk("inv_missr_line_invalid", 32'(ar_count - ar0), 32'd2);
      r_dly = 0;

      // reset in the middle of a refill burst; gaps and SLVERR data
      rand_gaps = 1; resp_mode = 2'b10; b0 = beats_acc;
      send(32'h1FC0_0114, 1'b0, w0);
      n = 0;
      while (beats_acc < b0 + 4 && n < 200) begin @(negedge clk); n++; end
      chk("midburst_beats", 32'(beats_acc >= b0 + 4), 32'd1);
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      check_reset("rst_midburst");
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      ar0 = ar_count;
      send(32'h1FC0_0000, 1'b0, w0);
      drain();
      chk("post_reset_miss", 32'(ar_count - ar0), 32'd1);
      ar0 = ar_count;
      send(32'h1FC0_0114, 1'b0, w0);
      drain();
      chk("post_reset_refill_ar", 32'(ar_count - ar0), 32'd1);
      chk("post_reset_araddr", last_araddr, 32'h1FC0_0100);
      send(32'h1FC0_011C, 1'b0, w0);
      drain();
      chk("post_reset_hit_no_ar", 32'(ar_count - ar0), 32'd1);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
